// File: rtl/dummy_sched_pkg.sv
// Shared types and helpers for the dummy round-robin scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dummy_sched_pkg;

   // Batch sequencer states: waiting for a mask, or draining grants.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sched_state_e;

   // Index width for n requesters. This never returns less than one bit, so a
   // degenerate count still yields a legal vector width.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dummy_rr_pick.sv
// Round-robin picker: chooses the lowest pending bit at or above rr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the pick follows pending and rr.
module dummy_rr_pick
   import dummy_sched_pkg::*;
#(
   parameter int unsigned NumReq    = 8,
   localparam int unsigned IdxWidth = idx_width(NumReq)
) (
   input  logic [NumReq-1:0]   pending,
   input  logic [IdxWidth-1:0] rr,
   output logic [IdxWidth-1:0] idx,
   output logic                last,
   output logic                any
);

   logic [NumReq-1:0]   hi_mask;
   logic [NumReq-1:0]   hi_pending;
   logic [NumReq-1:0]   pending_m1;
   logic [IdxWidth-1:0] hi_cnt;
   logic [IdxWidth-1:0] full_cnt;
   logic                hi_empty;
   logic                full_empty;

   // Keep only the requesters at or above the round-robin pointer.
   always_comb begin
      hi_mask = '0;
      for (int k = 0; k < NumReq; k++) begin
         hi_mask[k] = (k >= int'(rr));
      end
   end

   assign hi_pending = pending & hi_mask;

   lzc #(.WIDTH(NumReq), .MODE(1'b0)) u_lzc_hi (
      .in_i    (hi_pending),
      .cnt_o   (hi_cnt),
      .empty_o (hi_empty)
   );

   lzc #(.WIDTH(NumReq), .MODE(1'b0)) u_lzc_full (
      .in_i    (pending),
      .cnt_o   (full_cnt),
      .empty_o (full_empty)
   );

   // When nothing is pending at or above the pointer, wrap to the lowest pending bit.
   // Clearing the lowest set bit leaves zero only when exactly one bit is set.
   assign pending_m1 = pending - NumReq'(1);
   assign any        = ~full_empty;
   assign idx        = hi_empty ? full_cnt : hi_cnt;
   assign last       = any && ((pending & pending_m1) == '0);

endmodule

// File: rtl/lzc.sv
// Trailing-zero (MODE=0) or leading-zero (MODE=1) counter over WIDTH bits.
// Latency: purely combinational.
// Backpressure: none; the count follows the input.
module lzc #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MODE      = 1'b0,
   localparam int unsigned CNT_WIDTH = dummy_sched_pkg::idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o
);

   // Scan toward the winning end so that the last match seen is the one reported.
   // An all-zero input reports count 0 and sets empty_o.
   always_comb begin
      cnt_o   = '0;
      empty_o = ~|in_i;
      if (MODE == 1'b0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) cnt_o = CNT_WIDTH'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/dummy_rr_scheduler.sv
// Batch scheduler: takes a request mask and issues one grant index per handshake, round-robin.
// Latency: the mask is accepted at edge t and the first grant is valid in cycle t+1; each following grant takes one cycle.
// Backpressure: grants hold while gnt_ready_i is low; req_ready_o is high only in IDLE; flush_i drops the current batch.
module dummy_rr_scheduler
   import dummy_sched_pkg::*;
#(
   parameter int unsigned NumReq    = 8,
   localparam int unsigned IdxWidth = idx_width(NumReq)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [NumReq-1:0]   req_mask_i,
   output logic                gnt_valid_o,
   input  logic                gnt_ready_i,
   output logic [IdxWidth-1:0] gnt_idx_o,
   output logic                gnt_last_o,
   output logic                busy_o
);

   sched_state_e        state_q;
   logic [NumReq-1:0]   pending_q;
   logic [IdxWidth-1:0] rr_q;

   logic                pick_any;
   logic [NumReq-1:0]   gnt_onehot;
   logic [IdxWidth-1:0] rr_next;
   logic                gnt_fire;

   dummy_rr_pick #(.NumReq(NumReq)) u_pick (
      .pending (pending_q),
      .rr      (rr_q),
      .idx     (gnt_idx_o),
      .last    (gnt_last_o),
      .any     (pick_any)
   );

   // Handshake outputs are decoded directly from the state register.
   assign req_ready_o = (state_q == IDLE);
   assign gnt_valid_o = (state_q == GRANT);
   assign busy_o      = (state_q == GRANT);
   assign gnt_fire    = gnt_valid_o && gnt_ready_i;

   // The pointer moves one past the granted index and wraps at the top requester.
   assign gnt_onehot = NumReq'(1) << gnt_idx_o;
   assign rr_next    = (int'(gnt_idx_o) == NumReq - 1) ? '0 : gnt_idx_o + IdxWidth'(1);

   // Sequencer state: reset, flush, then batch acceptance or grant retirement.
   // The pointer survives flushes and batch ends so that fairness carries across batches.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         pending_q <= '0;
         rr_q      <= '0;
      end else if (flush_i) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  pending_q <= req_mask_i;
                  if (|req_mask_i) state_q <= GRANT;
               end
            end
            GRANT: begin
               if (!pick_any) begin
                  state_q <= IDLE;
               end else if (gnt_fire) begin
                  pending_q <= pending_q & ~gnt_onehot;
                  rr_q      <= rr_next;
                  if (gnt_last_o) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // While a grant is stalled without a flush, the offered index must not move.
   a_gnt_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (gnt_valid_o && !gnt_ready_i && !flush_i) |=> $stable(gnt_idx_o));

   // A grant is only ever offered with work still pending.
   a_gnt_has_work: assert property (@(posedge clk_i) disable iff (!rst_ni)
      gnt_valid_o |-> (pending_q != '0));

endmodule
